// File: rtl/seg_scan_display.sv
// Binary-to-BCD (sequential double-dabble) converter with multiplexed 7-segment scan output.
// Optional leading-zero blanking: define SEG_SCAN_LZ_BLANK_EN.
module seg_scan_display #(
  parameter int BIN_W           = 8,
  parameter int NUM_DIGITS      = 3,
  parameter int SCAN_DIV_W      = 10,
  parameter int SEG_ACTIVE_HIGH = 1,
  parameter int DIG_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      value_i,
  input  logic                  load_i,
  output logic                  busy_o,
  output logic [6:0]            seg_o,
  output logic [NUM_DIGITS-1:0] dig_en_o,
  output logic                  ovf_o
);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_HIGH != 0) ? 7'h00 : 7'h7F;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t            state, state_nx;
  logic [BIN_W-1:0]  shifter, pend_val, start_val;
  logic [BCD_W-1:0]  shadow, adj, disp;
  logic [CNT_W-1:0]  bit_cnt;
  logic              sticky, pend, start;
  logic [SCAN_DIV_W-1:0] presc;
  logic [IDX_W-1:0]  scan_idx;
  logic [3:0]        cur_dig;
  logic              blank;
  logic [6:0]        raw_seg, seg_nx;
  logic [NUM_DIGITS-1:0] dig_en_nx;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: return 7'h7E;
      4'd1: return 7'h30;
      4'd2: return 7'h6D;
      4'd3: return 7'h79;
      4'd4: return 7'h33;
      4'd5: return 7'h5B;
      4'd6: return 7'h5F;
      4'd7: return 7'h70;
      4'd8: return 7'h7F;
      4'd9: return 7'h73;
      default: return 7'h00;
    endcase
  endfunction

  always_comb begin
    adj = shadow;
    for (int unsigned d = 0; d < NUM_DIGITS; d++)
      if (shadow[4*d +: 4] > 4'd4) adj[4*d +: 4] = shadow[4*d +: 4] + 4'd3;
    state_nx  = state;
    start     = 1'b0;
    start_val = value_i;
    case (state)
      IDLE:
        if (load_i) begin
          start    = 1'b1;
          state_nx = SHIFT;
        end
      SHIFT:
        if (bit_cnt == '0) state_nx = COMMIT;
      COMMIT:
        // a load arriving in the commit cycle behaves like a pending load and wins over it
        if (pend || load_i) begin
          start     = 1'b1;
          start_val = load_i ? value_i : pend_val;
          state_nx  = SHIFT;
        end else begin
          state_nx = IDLE;
        end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shifter  <= '0;
      shadow   <= '0;
      bit_cnt  <= '0;
      sticky   <= 1'b0;
      pend     <= 1'b0;
      pend_val <= '0;
      disp     <= '0;
      ovf_o    <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) begin
        shifter <= start_val;
        shadow  <= '0;
        sticky  <= 1'b0;
        bit_cnt <= CNT_W'(BIN_W - 1);
      end else if (state == SHIFT) begin
        shadow  <= {adj[BCD_W-2:0], shifter[BIN_W-1]};
        shifter <= shifter << 1;
        if (adj[BCD_W-1]) sticky <= 1'b1;
        if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
      end
      if (state == COMMIT) begin
        disp  <= shadow;
        ovf_o <= sticky;
      end
      if (state == SHIFT && load_i) begin
        pend     <= 1'b1;
        pend_val <= value_i;
      end else if (state == COMMIT) begin
        pend <= 1'b0;
      end
    end
  end

  assign busy_o = (state != IDLE);

  always_comb begin
    cur_dig   = '0;
    dig_en_nx = '0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++)
      if (scan_idx == IDX_W'(d)) begin
        cur_dig      = disp[4*d +: 4];
        dig_en_nx[d] = 1'b1;
      end
    if (DIG_ACTIVE_LOW != 0) dig_en_nx = ~dig_en_nx;
    blank = 1'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
    // blank when this digit and every digit above it are zero; digit 0 always shows
    blank = (scan_idx != '0);
    for (int unsigned d = 0; d < NUM_DIGITS; d++)
      if (IDX_W'(d) >= scan_idx && disp[4*d +: 4] != 4'd0) blank = 1'b0;
`endif
    if (ovf_o)      raw_seg = 7'h01;
    else if (blank) raw_seg = 7'h00;
    else            raw_seg = seg_code(cur_dig);
    seg_nx = (SEG_ACTIVE_HIGH != 0) ? raw_seg : ~raw_seg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      scan_idx <= '0;
      seg_o    <= SEG_OFF;
      dig_en_o <= DIG_OFF;
    end else begin
      presc <= presc + 1'b1;
      if (presc == '1) begin
        seg_o    <= seg_nx;
        dig_en_o <= dig_en_nx;
        scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_display.sv
// Randomised + directed bench for seg_scan_display: two instances (default polarity, 3 digits;
// inverted polarity, 2 digits) against a value-level model of conversion timing and scanning.
module tb_seg_scan_display;
  localparam int BW = 8;
  localparam int SD = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] value_i = '0;
  logic          load_i = 1'b0;
  logic          busy_a, ovf_a, busy_b, ovf_b;
  logic [6:0]    seg_a, seg_b;
  logic [2:0]    en_a;
  logic [1:0]    en_b;

  always #5 clk = ~clk;

  seg_scan_display #(.BIN_W(BW), .NUM_DIGITS(3), .SCAN_DIV_W(SD),
                     .SEG_ACTIVE_HIGH(1), .DIG_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .value_i(value_i), .load_i(load_i),
    .busy_o(busy_a), .seg_o(seg_a), .dig_en_o(en_a), .ovf_o(ovf_a));

  seg_scan_display #(.BIN_W(BW), .NUM_DIGITS(2), .SCAN_DIV_W(SD),
                     .SEG_ACTIVE_HIGH(0), .DIG_ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .value_i(value_i), .load_i(load_i),
    .busy_o(busy_b), .seg_o(seg_b), .dig_en_o(en_b), .ovf_o(ovf_b));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h73};
  int nd  [2] = '{3, 2};
  bit sah [2] = '{1'b1, 1'b0};
  bit dal [2] = '{1'b1, 1'b0};

  // conversion model: cycles of busy remaining, value in flight, 1-deep latest-wins pending slot
  int m_left, m_cur, m_pend, m_disp, m_edges;
  bit m_pend_v;
  logic [6:0]  e_seg [2];
  logic [31:0] e_en  [2];

  function automatic logic [6:0] seg_for(int ndig, bit act_high, int val, int idx);
    logic [6:0] s;
    if (val >= 10**ndig) s = 7'h01;
    else begin
      s = seg_tab[(val / 10**idx) % 10];
`ifdef SEG_SCAN_LZ_BLANK_EN
      if (idx != 0 && val / 10**idx == 0) s = 7'h00;
`endif
    end
    return act_high ? s : ~s;
  endfunction

  function automatic logic [31:0] en_for(int ndig, bit act_low, int idx);
    logic [31:0] e;
    e = 32'd1 << idx;
    if (act_low) e = ~e & ((32'd1 << ndig) - 32'd1);
    return e;
  endfunction

  task automatic model_reset();
    m_left = 0; m_cur = 0; m_pend = 0; m_pend_v = 0; m_disp = 0; m_edges = 0;
    for (int k = 0; k < 2; k++) begin
      e_seg[k] = sah[k] ? 7'h00 : 7'h7F;
      e_en[k]  = dal[k] ? ((32'd1 << nd[k]) - 32'd1) : 32'd0;
    end
  endtask

  task automatic model_edge();
    m_edges++;
    if (m_edges % (1 << SD) == 0)
      for (int k = 0; k < 2; k++) begin
        e_seg[k] = seg_for(nd[k], sah[k], m_disp, ((m_edges >> SD) - 1) % nd[k]);
        e_en[k]  = en_for(nd[k], dal[k], ((m_edges >> SD) - 1) % nd[k]);
      end
    if (m_left == 0) begin
      if (load_i) begin m_cur = int'(value_i); m_left = BW + 1; end
    end else if (m_left == 1) begin
      m_disp = m_cur;
      if (load_i)        begin m_cur = int'(value_i); m_left = BW + 1; m_pend_v = 0; end
      else if (m_pend_v) begin m_cur = m_pend;        m_left = BW + 1; m_pend_v = 0; end
      else m_left = 0;
    end else begin
      if (load_i) begin m_pend = int'(value_i); m_pend_v = 1; end
      m_left--;
    end
  endtask

  task automatic check_outputs();
    check("busy_a", {31'd0, busy_a}, {31'd0, m_left > 0});
    check("busy_b", {31'd0, busy_b}, {31'd0, m_left > 0});
    check("ovf_a",  {31'd0, ovf_a},  {31'd0, m_disp >= 1000});
    check("ovf_b",  {31'd0, ovf_b},  {31'd0, m_disp >= 100});
    check("seg_a",  {25'd0, seg_a},  {25'd0, e_seg[0]});
    check("seg_b",  {25'd0, seg_b},  {25'd0, e_seg[1]});
    check("en_a",   {29'd0, en_a},   e_en[0]);
    check("en_b",   {30'd0, en_b},   e_en[1]);
  endtask

  task automatic step(input bit ld, input logic [BW-1:0] v);
    @(negedge clk);
    check_outputs();
    load_i  = ld;
    value_i = v;
    @(posedge clk);
    if (rst_n) model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    load_i = 1'b0;
    model_reset();
    #1 check_outputs();
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    model_reset();
    apply_reset();
    idle(5);
    step(1'b1, 8'd255); idle(40);
    step(1'b1, 8'd0);   idle(30);
    step(1'b1, 8'd12);  idle(2);
    step(1'b1, 8'd34);  idle(2);
    step(1'b1, 8'd56);  idle(40);
    step(1'b1, 8'd100); idle(30);
    step(1'b1, 8'd99);  idle(30);
    step(1'b1, 8'd8);   idle(30);
    step(1'b1, 8'd7);   idle(30);
    // load landing exactly in the commit cycle
    step(1'b1, 8'd42);  idle(8);
    step(1'b1, 8'd199); idle(40);
    step(1'b1, 8'd200); idle(4);
    apply_reset();
    idle(30);
    for (int i = 0; i < 600; i++) begin
      if (i == 300) apply_reset();
      step($urandom_range(0, 5) == 0, BW'($urandom));
    end
    idle(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
